// File: rtl/traffic_light_pkg.sv
// Shared types for the intersection car light and its consumers.
//   traffic_light_t  : car light encoding (2'b11 is not a legal light)
//   ped_state_t      : pedestrian crossing controller phases
//   legal_light_step : 1 when prev -> cur is an allowed car light step
package traffic_light_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } traffic_light_t;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WALK,
    FLASH,
    CLEAR
  } ped_state_t;

  // Allowed steps: hold the same light, or advance G->Y, Y->R, R->G.
  // Any step touching the unused encoding is illegal, even "holding" it.
  function automatic bit legal_light_step(input traffic_light_t prev,
                                          input traffic_light_t cur);
    bit ok;
    ok = 1'b0;
    case ({prev, cur})
      {GREEN,  GREEN }: ok = 1'b1;
      {YELLOW, YELLOW}: ok = 1'b1;
      {RED,    RED   }: ok = 1'b1;
      {GREEN,  YELLOW}: ok = 1'b1;
      {YELLOW, RED   }: ok = 1'b1;
      {RED,    GREEN }: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ped_phase_timer.sv
// Down counter timing the WALK / FLASH / CLEAR phases.
//   clk, asyn_n_reset : clock, synchronous active-low reset
//   load, load_value  : load a phase length (wins over enable)
//   enable            : decrement while non-zero
//   value             : current count
//   done              : count is 1, i.e. this is the last cycle of the phase
module ped_phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          asyn_n_reset,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  input  logic          enable,
  output logic [TW-1:0] value,
  output logic          done
);

  logic [TW-1:0] value_q;
  logic [TW-1:0] value_d;

  // Saturate at zero so an idle timer never wraps into a false done.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (enable && (value_q != '0)) begin
      value_d = value_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!asyn_n_reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign done  = (value_q == TW'(1));

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller beside the intersection car light.
// Latches crossing requests, asks the light controller to hold RED, runs
// WALK -> FLASH -> CLEAR once RED is seen, and checks the car light sequence.
//   clk, asyn_n_reset : clock, synchronous active-low reset
//   car_light         : observed car light
//   button            : pedestrian request level
//   req_pending       : request latched, not yet served
//   hold_red          : ask the light controller to reach / keep RED
//   walk, dont_walk   : pedestrian lamps
//   countdown         : cycles left of WALK+FLASH, 0 elsewhere
//   seq_err           : sticky, illegal car light step observed
//   conflict_err      : sticky, car light left RED during a pedestrian phase
module ped_crossing_ctrl
  import traffic_light_pkg::*;
#(
  parameter int WALK_CYCLES  = 8,
  parameter int FLASH_CYCLES = 6,
  parameter int CLEAR_CYCLES = 2,
  // Derived from the phase lengths; not meant to be overridden.
  parameter int CW = $clog2(WALK_CYCLES + FLASH_CYCLES + 1)
) (
  input  logic           clk,
  input  logic           asyn_n_reset,
  input  traffic_light_t car_light,
  input  logic           button,
  output logic           req_pending,
  output logic           hold_red,
  output logic           walk,
  output logic           dont_walk,
  output logic [CW-1:0]  countdown,
  output logic           seq_err,
  output logic           conflict_err
);

  localparam int TW = $clog2(WALK_CYCLES + FLASH_CYCLES + CLEAR_CYCLES + 1);

  ped_state_t    state_q, state_d;
  logic          req_pending_q, req_pending_d;
  logic          hold_red_q, hold_red_d;
  logic          walk_q, walk_d;
  logic          dont_walk_q, dont_walk_d;
  logic [CW-1:0] countdown_q, countdown_d;
  logic          conflict_err_q, conflict_err_d;
  logic          seq_err_q, seq_err_d;
  traffic_light_t prev_light_q;
  logic          prev_valid_q;

  logic          timer_load;
  logic [TW-1:0] timer_load_value;
  logic [TW-1:0] timer_value;
  logic          timer_done;
  logic          ped_active;
  logic          conflict;

  ped_phase_timer #(.TW(TW)) u_timer (
    .clk         (clk),
    .asyn_n_reset(asyn_n_reset),
    .load        (timer_load),
    .load_value  (timer_load_value),
    .enable      (1'b1),
    .value       (timer_value),
    .done        (timer_done)
  );

  assign ped_active = (state_q == WALK) || (state_q == FLASH) || (state_q == CLEAR);
  assign conflict   = ped_active && (car_light != RED);

  // State register.
  always_ff @(posedge clk) begin
    if (!asyn_n_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. Conflict is tested before the timer so it beats expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_pending_q) begin
          state_d = (car_light == RED) ? WALK : ARM;
        end
      end
      ARM: begin
        if (car_light == RED) state_d = WALK;
      end
      WALK: begin
        if (conflict)        state_d = IDLE;
        else if (timer_done) state_d = FLASH;
      end
      FLASH: begin
        if (conflict)        state_d = IDLE;
        else if (timer_done) state_d = CLEAR;
      end
      CLEAR: begin
        if (conflict || timer_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and timer control, all computed for the state being entered so
  // every registered output lines up with state_q.
  always_comb begin
    timer_load       = (state_d != state_q);
    timer_load_value = '0;
    case (state_d)
      WALK:    timer_load_value = TW'(WALK_CYCLES);
      FLASH:   timer_load_value = TW'(FLASH_CYCLES);
      CLEAR:   timer_load_value = TW'(CLEAR_CYCLES);
      default: timer_load_value = '0;
    endcase

    // Serving the request clears it; a press that same cycle is dropped.
    req_pending_d = req_pending_q;
    if (((state_q == IDLE) || (state_q == ARM)) && (state_d == WALK)) begin
      req_pending_d = 1'b0;
    end else if (button && (state_q != WALK)) begin
      req_pending_d = 1'b1;
    end

    hold_red_d = (state_d != IDLE);

    walk_d = 1'b0;
    if (state_d == WALK) begin
      walk_d = 1'b1;
    end else if (state_d == FLASH) begin
      walk_d = (state_q == FLASH) ? ~walk_q : 1'b0;
    end
    dont_walk_d = !((state_d == WALK) || (state_d == FLASH));

    countdown_d = '0;
    if ((state_d == WALK) && (state_q != WALK)) begin
      countdown_d = CW'(WALK_CYCLES + FLASH_CYCLES);
    end else if ((state_d == WALK) || (state_d == FLASH)) begin
      countdown_d = countdown_q - CW'(1);
    end

    conflict_err_d = conflict_err_q | conflict;
  end

  always_ff @(posedge clk) begin
    if (!asyn_n_reset) begin
      req_pending_q  <= 1'b0;
      hold_red_q     <= 1'b0;
      walk_q         <= 1'b0;
      dont_walk_q    <= 1'b1;
      countdown_q    <= '0;
      conflict_err_q <= 1'b0;
    end else begin
      req_pending_q  <= req_pending_d;
      hold_red_q     <= hold_red_d;
      walk_q         <= walk_d;
      dont_walk_q    <= dont_walk_d;
      countdown_q    <= countdown_d;
      conflict_err_q <= conflict_err_d;
    end
  end

  // Car light sequence checker, independent of the pedestrian FSM. The first
  // cycle after reset has no previous light to compare against.
  always_comb begin
    seq_err_d = seq_err_q;
    if (prev_valid_q && !legal_light_step(prev_light_q, car_light)) begin
      seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!asyn_n_reset) begin
      seq_err_q    <= 1'b0;
      prev_light_q <= GREEN;
      prev_valid_q <= 1'b0;
    end else begin
      seq_err_q    <= seq_err_d;
      prev_light_q <= car_light;
      prev_valid_q <= 1'b1;
    end
  end

  assign req_pending  = req_pending_q;
  assign hold_red     = hold_red_q;
  assign walk         = walk_q;
  assign dont_walk    = dont_walk_q;
  assign countdown    = countdown_q;
  assign seq_err      = seq_err_q;
  assign conflict_err = conflict_err_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed scenarios followed by randomized
// traffic. A reference model tracks the crossing as "cycles since WALK began"
// and derives the lamps arithmetically; its expected outputs go into a queue
// that a separate monitor drains and compares after every clock edge.
module tb_ped_crossing_ctrl;
  import traffic_light_pkg::*;

  localparam int W  = 8;
  localparam int F  = 6;
  localparam int C  = 2;
  localparam int CW = $clog2(W + F + 1);

  logic           clk;
  logic           asyn_n_reset;
  traffic_light_t car_light;
  logic           button;
  logic           req_pending;
  logic           hold_red;
  logic           walk;
  logic           dont_walk;
  logic [CW-1:0]  countdown;
  logic           seq_err;
  logic           conflict_err;

  ped_crossing_ctrl #(
    .WALK_CYCLES (W),
    .FLASH_CYCLES(F),
    .CLEAR_CYCLES(C)
  ) dut (
    .clk         (clk),
    .asyn_n_reset(asyn_n_reset),
    .car_light   (car_light),
    .button      (button),
    .req_pending (req_pending),
    .hold_red    (hold_red),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .countdown   (countdown),
    .seq_err     (seq_err),
    .conflict_err(conflict_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int req;
    int hold;
    int walk;
    int dw;
    int cd;
    int seq;
    int conf;
  } exp_t;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  // Reference model state.
  bit m_active;
  int m_t;
  bit m_wait;
  bit m_req;
  bit m_seq;
  bit m_conf;
  int m_prev;
  bit m_prev_valid;

  int cur_light;

  task automatic modelStep(input bit rst_n, input bit btn, input int light);
    bit in_walk;
    bit enter;
    int prev_l;
    bit pv;
    if (!rst_n) begin
      m_active = 0; m_t = 0; m_wait = 0; m_req = 0; m_seq = 0; m_conf = 0;
    end else begin
      in_walk = m_active && (m_t < W);
      enter   = 0;
      prev_l  = m_prev;
      pv      = m_prev_valid;
      if (m_active) begin
        if (light != 2) begin
          m_active = 0; m_wait = 0; m_conf = 1;
        end else if (m_t == W + F + C - 1) begin
          m_active = 0;
        end else begin
          m_t = m_t + 1;
        end
      end else if (m_req) begin
        if (light == 2) begin
          m_active = 1; m_t = 0; m_wait = 0; enter = 1;
        end else begin
          m_wait = 1;
        end
      end
      if (enter) m_req = 0;
      else if (btn && !in_walk) m_req = 1;
      if (pv && !(prev_l < 3 && light < 3 &&
                  (light == prev_l || light == (prev_l + 1) % 3))) m_seq = 1;
    end
    m_prev       = light;
    m_prev_valid = rst_n;
  endtask

  function automatic exp_t modelOutputs();
    exp_t e;
    bit lit;
    lit    = m_active && (m_t < W + F);
    e.req  = m_req;
    e.hold = m_active || m_wait;
    e.walk = m_active && ((m_t < W) || (lit && ((m_t - W) % 2 == 1)));
    e.dw   = !lit;
    e.cd   = lit ? (W + F - m_t) : 0;
    e.seq  = m_seq;
    e.conf = m_conf;
    return e;
  endfunction

  task automatic applyStimulus(input bit rst_n, input bit btn, input int light);
    @(negedge clk);
    asyn_n_reset = rst_n;
    button       = btn;
    car_light    = traffic_light_t'(light[1:0]);
    modelStep(rst_n, btn, light);
    sb.push_back(modelOutputs());
  endtask

  task automatic runFor(input int n, input bit rst_n, input bit btn, input int light);
    for (int i = 0; i < n; i++) applyStimulus(rst_n, btn, light);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Monitor: the DUT presents a fresh output set after every edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("req_pending",  int'(req_pending),  e.req);
      checkOutput("hold_red",     int'(hold_red),     e.hold);
      checkOutput("walk",         int'(walk),         e.walk);
      checkOutput("dont_walk",    int'(dont_walk),    e.dw);
      checkOutput("countdown",    int'(countdown),    e.cd);
      checkOutput("seq_err",      int'(seq_err),      e.seq);
      checkOutput("conflict_err", int'(conflict_err), e.conf);
    end
  end

  function automatic int advanceLight(input int l);
    return (l >= 2) ? 0 : l + 1;
  endfunction

  initial begin
    bit rst_n;
    bit btn;
    tests_run    = 0;
    tests_failed = 0;
    m_active = 0; m_t = 0; m_wait = 0; m_req = 0;
    m_seq = 0; m_conf = 0; m_prev = 0; m_prev_valid = 0;
    asyn_n_reset = 1'b0;
    button       = 1'b0;
    car_light    = GREEN;

    // Reset state at GREEN.
    runFor(3, 0, 0, 0);
    // Full crossing requested at GREEN: ARM, light walks to RED, phases run.
    runFor(2, 1, 0, 0);
    applyStimulus(1, 1, 0);
    runFor(3, 1, 0, 0);
    runFor(2, 1, 0, 1);
    runFor(22, 1, 0, 2);
    // Request while RED already showing, then conflict at countdown 10.
    applyStimulus(1, 1, 2);
    runFor(5, 1, 0, 2);
    applyStimulus(1, 0, 0);
    runFor(3, 1, 0, 0);
    // GREEN -> RED directly is illegal and sticks until reset.
    applyStimulus(1, 0, 2);
    runFor(3, 1, 0, 2);
    runFor(2, 0, 0, 2);
    applyStimulus(1, 0, 3);
    applyStimulus(1, 0, 0);
    runFor(2, 1, 0, 0);
    // Reset during FLASH, then button held through WALK and pressed in CLEAR.
    runFor(1, 0, 0, 2);
    runFor(1, 1, 0, 2);
    applyStimulus(1, 1, 2);
    runFor(12, 1, 0, 2);
    applyStimulus(0, 0, 2);
    runFor(1, 1, 0, 2);
    runFor(10, 1, 1, 2);
    runFor(6, 1, 0, 2);
    applyStimulus(1, 1, 2);
    runFor(24, 1, 0, 2);

    // Randomized traffic: the light mostly honours hold_red like a real
    // controller, with occasional illegal jumps, conflicts and resets.
    cur_light = 2;
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      btn   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 299) == 0) begin
        cur_light = $urandom_range(0, 3);
      end else if (m_active || m_wait) begin
        if (cur_light == 2) begin
          if ($urandom_range(0, 199) == 0) cur_light = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          cur_light = advanceLight(cur_light);
        end
      end else if ($urandom_range(0, 9) == 0) begin
        cur_light = advanceLight(cur_light);
      end
      applyStimulus(rst_n, btn, cur_light);
    end

    // Let the monitor drain the last expectations.
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
